// File: rtl/multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// multicycle_control_unit
//
// Purpose:
//   FSM-based RV32I control unit for the multi-cycle core. It steps each
//   instruction through FETCH, DECODE, EXEC, MEM and WB, latches the opcode and
//   funct fields on the fetch handshake, waits on the instruction- and
//   data-memory valid handshakes, and traps on unknown opcodes, illegal funct
//   combinations and data-memory timeouts. The datapath selects match the
//   single-cycle decoder, qualified by state.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   IM_valid              instruction word valid on opcode_i/fun3/fun7
//   opcode_i, fun3, fun7  instruction opcode, funct3 and instruction bit 30
//   DM_valid              data memory completed the current access
//   im_req, ir_write      fetch request and instruction-field latch enable
//   pc_write              PC update strobe, one cycle per retired instruction
//   mem_en                data memory request, held through MEM
//   Load, Store, Branch, next_sel, Jalr   type flags, valid DECODE..WB
//   reg_write_o           register file write (WB only)
//   operand_a_o/_b_o      ALU operand selects (1 = PC / 1 = immediate)
//   imm_sel, mem_to_reg   immediate format and write-back source selects
//   alu_control           ALU operation
//   illegal_o, timeout_o  sticky trap causes
//   state_o               FETCH0 DECODE1 EXEC2 MEM3 WB4 TRAP7
// ----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int FUNCTION3   = 3,
    parameter int OPCODE      = 7,
    parameter int ALU_CONTROL = 4,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IM_valid,
    input  logic [OPCODE-1:0]      opcode_i,
    input  logic [FUNCTION3-1:0]   fun3,
    input  logic                   fun7,
    input  logic                   DM_valid,
    output logic                   im_req,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   mem_en,
    output logic                   Load,
    output logic                   Store,
    output logic                   Branch,
    output logic                   next_sel,
    output logic                   Jalr,
    output logic                   reg_write_o,
    output logic                   operand_a_o,
    output logic                   operand_b_o,
    output logic [2:0]             imm_sel,
    output logic [1:0]             mem_to_reg,
    output logic [ALU_CONTROL-1:0] alu_control,
    output logic                   illegal_o,
    output logic                   timeout_o,
    output logic [2:0]             state_o
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPCODE-1:0] OP_R      = 7'b0110011;
    localparam logic [OPCODE-1:0] OP_I      = 7'b0010011;
    localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_CONTROL-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_CONTROL-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_CONTROL-1:0] ALU_SLL  = 4'd2;
    localparam logic [ALU_CONTROL-1:0] ALU_SLT  = 4'd3;
    localparam logic [ALU_CONTROL-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALU_CONTROL-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_CONTROL-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_CONTROL-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_CONTROL-1:0] ALU_OR   = 4'd8;
    localparam logic [ALU_CONTROL-1:0] ALU_AND  = 4'd9;
    localparam logic [ALU_CONTROL-1:0] ALU_LUI  = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t                 state;
    logic [OPCODE-1:0]      opcode_q;
    logic [FUNCTION3-1:0]   fun3_q;
    logic                   fun7_q;
    logic [TO_W-1:0]        to_cnt;
    logic                   illegal_q;
    logic                   timeout_q;

    logic                   is_r, is_i, is_load, is_store, is_branch;
    logic                   is_jal, is_jalr, is_lui, is_auipc, known;
    logic                   funct_ok;
    logic [ALU_CONTROL-1:0] alu_dec;

    // Decode the latched instruction fields into type flags, a legality
    // verdict and an ALU operation. Everything here looks only at the latched
    // copy, so IM_valid activity after the fetch cannot disturb an instruction
    // already in flight. Unknown opcodes leave every type flag low, which also
    // keeps the datapath selects at zero for them.
    always_comb begin
        is_r      = (opcode_q == OP_R);
        is_i      = (opcode_q == OP_I);
        is_load   = (opcode_q == OP_LOAD);
        is_store  = (opcode_q == OP_STORE);
        is_branch = (opcode_q == OP_BRANCH);
        is_jal    = (opcode_q == OP_JAL);
        is_jalr   = (opcode_q == OP_JALR);
        is_lui    = (opcode_q == OP_LUI);
        is_auipc  = (opcode_q == OP_AUIPC);
        known     = is_r | is_i | is_load | is_store | is_branch |
                    is_jal | is_jalr | is_lui | is_auipc;

        // Bit 30 only selects SUB (register form) and SRA; anywhere else it is
        // an illegal encoding. Loads reject the unused widths and stores only
        // allow byte, half and word.
        funct_ok = 1'b1;
        if (is_r) begin
            funct_ok = !fun7_q || (fun3_q == 3'b000) || (fun3_q == 3'b101);
        end else if (is_i) begin
            funct_ok = !fun7_q || (fun3_q == 3'b101);
        end else if (is_load) begin
            funct_ok = !((fun3_q == 3'b011) || (fun3_q == 3'b110) || (fun3_q == 3'b111));
        end else if (is_store) begin
            funct_ok = (fun3_q <= 3'b010);
        end

        alu_dec = ALU_ADD;
        if (is_r || is_i) begin
            case (fun3_q)
                3'b000:  alu_dec = (is_r && fun7_q) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_dec = ALU_SLL;
                3'b010:  alu_dec = ALU_SLT;
                3'b011:  alu_dec = ALU_SLTU;
                3'b100:  alu_dec = ALU_XOR;
                3'b101:  alu_dec = fun7_q ? ALU_SRA : ALU_SRL;
                3'b110:  alu_dec = ALU_OR;
                default: alu_dec = ALU_AND;
            endcase
        end else if (is_branch) begin
            case (fun3_q[2:1])
                2'b10:   alu_dec = ALU_SLT;
                2'b11:   alu_dec = ALU_SLTU;
                default: alu_dec = ALU_SUB;
            endcase
        end else if (is_lui) begin
            alu_dec = ALU_LUI;
        end
    end

    // Main sequencer. Reset dominates every state, so an outstanding data
    // access is simply dropped and the next cycle starts a fresh fetch. The
    // MEM wait counter counts cycles without DM_valid; the cycle that would
    // bring it to MEM_TIMEOUT traps instead, unless DM_valid arrives in that
    // same cycle, in which case the access completes normally. The counter is
    // cleared on every MEM exit so the next access gets the full budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            opcode_q  <= '0;
            fun3_q    <= '0;
            fun7_q    <= 1'b0;
            to_cnt    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (IM_valid) begin
                        opcode_q <= opcode_i;
                        fun3_q   <= fun3;
                        fun7_q   <= fun7;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!known || !funct_ok) begin
                        illegal_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) begin
                        state <= S_MEM;
                    end else if (is_branch) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (DM_valid) begin
                        to_cnt <= '0;
                        state  <= is_load ? S_WB : S_FETCH;
                    end else if (to_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                        to_cnt    <= '0;
                        timeout_q <= 1'b1;
                        state     <= S_TRAP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_WB: begin
                    state <= S_FETCH;
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end

    // Output decode. Strobes depend only on the state (plus the handshake
    // inputs that complete a step), while the type flags and datapath selects
    // are shown from DECODE through WB and forced low in FETCH and TRAP.
    always_comb begin
        logic active;
        active      = (state == S_DECODE) || (state == S_EXEC) ||
                      (state == S_MEM)    || (state == S_WB);

        im_req      = (state == S_FETCH);
        ir_write    = (state == S_FETCH) && IM_valid;
        mem_en      = (state == S_MEM);
        reg_write_o = (state == S_WB);
        pc_write    = ((state == S_EXEC) && is_branch) ||
                      ((state == S_MEM) && DM_valid && is_store) ||
                      (state == S_WB);

        Load        = 1'b0;
        Store       = 1'b0;
        Branch      = 1'b0;
        next_sel    = 1'b0;
        Jalr        = 1'b0;
        operand_a_o = 1'b0;
        operand_b_o = 1'b0;
        imm_sel     = 3'b000;
        mem_to_reg  = 2'b00;
        alu_control = '0;

        if (active) begin
            Load        = is_load;
            Store       = is_store;
            Branch      = is_branch;
            next_sel    = is_jal;
            Jalr        = is_jalr;
            operand_a_o = is_branch | is_jal | is_auipc;
            operand_b_o = known && !is_r;
            alu_control = alu_dec;
            if (is_store) begin
                imm_sel = 3'b001;
            end else if (is_branch) begin
                imm_sel = 3'b010;
            end else if (is_jal) begin
                imm_sel = 3'b011;
            end else if (is_lui || is_auipc) begin
                imm_sel = 3'b100;
            end
            if (is_load) begin
                mem_to_reg = 2'b01;
            end else if (is_jal || is_jalr) begin
                mem_to_reg = 2'b10;
            end
        end

        illegal_o = illegal_q;
        timeout_o = timeout_q;
        state_o   = state;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Purpose:
//   Self-checking bench for multicycle_control_unit. A driver walks each
//   instruction through its expected phase sequence, computed from the
//   instruction class, and queues the full expected output vector for every
//   cycle. A monitor samples the DUT on the falling edge, pops the queue and
//   compares. Directed cases cover the listed scenarios; the rest is random.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int MEM_TIMEOUT = 16;

    typedef enum int {PH_F, PH_D, PH_E, PH_M, PH_W, PH_T} phase_t;

    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       op_a;
        logic       op_b;
        logic [2:0] imm;
        logic [1:0] m2r;
        logic [3:0] alu;
    } info_t;

    typedef struct packed {
        logic [2:0] state;
        logic       im_req;
        logic       ir_write;
        logic       pc_write;
        logic       mem_en;
        logic       reg_write;
        logic       load;
        logic       store;
        logic       branch;
        logic       next_sel;
        logic       jalr;
        logic       op_a;
        logic       op_b;
        logic [2:0] imm;
        logic [1:0] m2r;
        logic [3:0] alu;
        logic       ill;
        logic       to;
    } out_t;

    logic       clk;
    logic       reset;
    logic       IM_valid;
    logic [6:0] opcode_i;
    logic [2:0] fun3;
    logic       fun7;
    logic       DM_valid;
    logic       im_req, ir_write, pc_write, mem_en;
    logic       Load, Store, Branch, next_sel, Jalr;
    logic       reg_write_o, operand_a_o, operand_b_o;
    logic [2:0] imm_sel;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_control;
    logic       illegal_o, timeout_o;
    logic [2:0] state_o;

    out_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cycle_no = 0;

    logic [6:0] op_table [9];
    logic [3:0] alu_by_fun3 [8];

    multicycle_control_unit #(
        .FUNCTION3  (3),
        .OPCODE     (7),
        .ALU_CONTROL(4),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .IM_valid   (IM_valid),
        .opcode_i   (opcode_i),
        .fun3       (fun3),
        .fun7       (fun7),
        .DM_valid   (DM_valid),
        .im_req     (im_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .mem_en     (mem_en),
        .Load       (Load),
        .Store      (Store),
        .Branch     (Branch),
        .next_sel   (next_sel),
        .Jalr       (Jalr),
        .reg_write_o(reg_write_o),
        .operand_a_o(operand_a_o),
        .operand_b_o(operand_b_o),
        .imm_sel    (imm_sel),
        .mem_to_reg (mem_to_reg),
        .alu_control(alu_control),
        .illegal_o  (illegal_o),
        .timeout_o  (timeout_o),
        .state_o    (state_o)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the driver ever stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Instruction-class table: what each opcode means to the datapath.
    function automatic info_t describe(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        info_t i;
        i       = '0;
        i.legal = 1'b1;
        case (op)
            7'b0110011: begin
                i.alu   = alu_by_fun3[f3];
                if (f7 && f3 == 3'd0) i.alu = 4'd1;
                if (f7 && f3 == 3'd5) i.alu = 4'd7;
                i.legal = !f7 || f3 == 3'd0 || f3 == 3'd5;
            end
            7'b0010011: begin
                i.op_b  = 1'b1;
                i.alu   = alu_by_fun3[f3];
                if (f7 && f3 == 3'd5) i.alu = 4'd7;
                i.legal = !f7 || f3 == 3'd5;
            end
            7'b0000011: begin
                i.op_b = 1'b1; i.is_load = 1'b1; i.m2r = 2'b01;
                i.legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            end
            7'b0100011: begin
                i.op_b = 1'b1; i.is_store = 1'b1; i.imm = 3'd1;
                i.legal = f3 <= 3'd2;
            end
            7'b1100011: begin
                i.op_a = 1'b1; i.op_b = 1'b1; i.is_branch = 1'b1; i.imm = 3'd2;
                i.alu  = !f3[2] ? 4'd1 : (f3[1] ? 4'd4 : 4'd3);
            end
            7'b1101111: begin
                i.op_a = 1'b1; i.op_b = 1'b1; i.is_jal = 1'b1; i.imm = 3'd3; i.m2r = 2'b10;
            end
            7'b1100111: begin
                i.op_b = 1'b1; i.is_jalr = 1'b1; i.m2r = 2'b10;
            end
            7'b0110111: begin
                i.op_b = 1'b1; i.imm = 3'd4; i.alu = 4'd15;
            end
            7'b0010111: begin
                i.op_a = 1'b1; i.op_b = 1'b1; i.imm = 3'd4;
            end
            default: i.legal = 1'b0;
        endcase
        return i;
    endfunction

    // Expected outputs for one cycle given the phase the instruction is in.
    function automatic out_t expect_vec(input phase_t ph, input info_t i, input logic imv,
                                        input logic dmv, input logic ill, input logic to);
        out_t v;
        v = '0;
        if (ph == PH_F) begin
            v.state    = 3'd0;
            v.im_req   = 1'b1;
            v.ir_write = imv;
        end else if (ph == PH_T) begin
            v.state = 3'd7;
            v.ill   = ill;
            v.to    = to;
        end else begin
            v.load     = i.is_load;
            v.store    = i.is_store;
            v.branch   = i.is_branch;
            v.next_sel = i.is_jal;
            v.jalr     = i.is_jalr;
            v.op_a     = i.op_a;
            v.op_b     = i.op_b;
            v.imm      = i.imm;
            v.m2r      = i.m2r;
            v.alu      = i.alu;
            case (ph)
                PH_D: v.state = 3'd1;
                PH_E: begin v.state = 3'd2; v.pc_write = i.is_branch; end
                PH_M: begin v.state = 3'd3; v.mem_en = 1'b1; v.pc_write = dmv && i.is_store; end
                default: begin v.state = 3'd4; v.reg_write = 1'b1; v.pc_write = 1'b1; end
            endcase
        end
        return v;
    endfunction

    // One clock cycle of stimulus: drive inputs, queue the expectation.
    task automatic drive_cycle(input logic rst, input logic imv, input logic [6:0] op,
                               input logic [2:0] f3, input logic f7, input logic dmv,
                               input out_t e);
        reset    = rst;
        IM_valid = imv;
        opcode_i = op;
        fun3     = f3;
        fun7     = f7;
        DM_valid = dmv;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // A cycle outside FETCH: IM_valid and the fields are random noise.
    task automatic busy_cycle(input phase_t ph, input info_t i, input logic dmv);
        drive_cycle(1'b0, 1'($urandom_range(0, 1)), 7'($urandom), 3'($urandom),
                    1'($urandom_range(0, 1)), dmv, expect_vec(ph, i, 1'b0, dmv, 1'b0, 1'b0));
    endtask

    // Sit in TRAP for a few cycles with noisy inputs, then reset out of it.
    task automatic trap_hold(input logic ill, input logic to);
        repeat (3) begin
            drive_cycle(1'b0, 1'($urandom_range(0, 1)), 7'($urandom), 3'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        expect_vec(PH_T, '0, 1'b0, 1'b0, ill, to));
        end
        drive_cycle(1'b1, 1'b0, 7'd0, 3'd0, 1'b0, 1'b0, expect_vec(PH_T, '0, 1'b0, 1'b0, ill, to));
    endtask

    // Issue one instruction: idle fetch cycles, the fetch handshake, then the
    // phases that instruction class goes through. k is the number of MEM wait
    // cycles before DM_valid; reset_at is the MEM cycle index to reset in.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input int idle, input int k, input int reset_at);
        info_t i;
        logic  dmv;
        i = describe(op, f3, f7);
        repeat (idle) begin
            drive_cycle(1'b0, 1'b0, 7'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), expect_vec(PH_F, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        drive_cycle(1'b0, 1'b1, op, f3, f7, 1'($urandom_range(0, 1)),
                    expect_vec(PH_F, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        busy_cycle(PH_D, i, 1'($urandom_range(0, 1)));
        if (!i.legal) begin
            trap_hold(1'b1, 1'b0);
            return;
        end
        busy_cycle(PH_E, i, 1'($urandom_range(0, 1)));
        if (i.is_branch) return;
        if (i.is_load || i.is_store) begin
            for (int m = 0; m < MEM_TIMEOUT; m++) begin
                if (m == reset_at) begin
                    drive_cycle(1'b1, 1'b0, 7'd0, 3'd0, 1'b0, 1'b0,
                                expect_vec(PH_M, i, 1'b0, 1'b0, 1'b0, 1'b0));
                    return;
                end
                dmv = (m == k);
                busy_cycle(PH_M, i, dmv);
                if (dmv) begin
                    if (i.is_store) return;
                    break;
                end
                if (m == MEM_TIMEOUT - 1) begin
                    trap_hold(1'b0, 1'b1);
                    return;
                end
            end
        end
        busy_cycle(PH_W, i, 1'($urandom_range(0, 1)));
    endtask

    // Compare one sampled DUT cycle against the queued expectation.
    task automatic checkOutput(input out_t e);
        out_t a;
        a = {state_o, im_req, ir_write, pc_write, mem_en, reg_write_o, Load, Store, Branch,
             next_sel, Jalr, operand_a_o, operand_b_o, imm_sel, mem_to_reg, alu_control,
             illegal_o, timeout_o};
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL cycle_%0d outputs: got state=%0d vec=%h, expected state=%0d vec=%h",
                     cycle_no, a.state, a, e.state, e);
        end
    endtask

    // Monitor: every falling edge, pop the next expectation and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
                cycle_no++;
            end
        end
    end

    // Driver: directed scenarios first, then random instructions.
    initial begin
        logic [6:0] op;
        int         k;
        int         rst_at;
        op_table    = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        alu_by_fun3 = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        reset    = 1'b1;
        IM_valid = 1'b0;
        opcode_i = 7'd0;
        fun3     = 3'd0;
        fun7     = 1'b0;
        DM_valid = 1'b0;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 1'b0, 7'd0, 3'd0, 1'b0, 1'b0, expect_vec(PH_F, '0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("[TB] directed scenarios");
        applyStimulus(7'b0110011, 3'b000, 1'b0, 0, 0, 99);
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1, 0, 99);
        applyStimulus(7'b0110011, 3'b101, 1'b1, 0, 0, 99);
        applyStimulus(7'b0010011, 3'b101, 1'b1, 0, 0, 99);
        applyStimulus(7'b0010011, 3'b001, 1'b1, 0, 0, 99);
        applyStimulus(7'b0000011, 3'b010, 1'b0, 0, 3, 99);
        applyStimulus(7'b0100011, 3'b010, 1'b0, 0, 999, 99);
        applyStimulus(7'b1100011, 3'b000, 1'b0, 0, 0, 99);
        applyStimulus(7'b1101111, 3'b000, 1'b0, 0, 0, 99);
        applyStimulus(7'b0000011, 3'b010, 1'b0, 0, 5, 1);
        applyStimulus(7'b0000011, 3'b000, 1'b0, 0, MEM_TIMEOUT - 1, 99);
        applyStimulus(7'b0100011, 3'b001, 1'b0, 2, 0, 99);
        applyStimulus(7'b0000011, 3'b110, 1'b0, 0, 0, 99);
        applyStimulus(7'b0100011, 3'b011, 1'b0, 0, 0, 99);
        applyStimulus(7'b1111111, 3'b000, 1'b0, 0, 0, 99);
        applyStimulus(7'b0110111, 3'b000, 1'b0, 0, 0, 99);

        $display("[TB] random instructions");
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = op_table[$urandom_range(0, 8)];
            if ($urandom_range(0, 4) == 0) k = $urandom_range(MEM_TIMEOUT - 2, MEM_TIMEOUT + 3);
            else k = $urandom_range(0, 4);
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : 99;
            applyStimulus(op, 3'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                          k, rst_at);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
